// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: the four control-token symbols and the
// per-channel alignment state encoding.
package tmds_pkg;

  localparam logic [9:0] TokenC0 = 10'h354;
  localparam logic [9:0] TokenC1 = 10'h0AB;
  localparam logic [9:0] TokenC2 = 10'h154;
  localparam logic [9:0] TokenC3 = 10'h2AB;

  typedef enum logic [1:0] {
    StSearch,
    StSlip,
    StAligned
  } ch_state_e;

  function automatic logic is_token(logic [9:0] sym);
    return (sym == TokenC0) || (sym == TokenC1) || (sym == TokenC2) || (sym == TokenC3);
  endfunction

  function automatic logic [1:0] token_code(logic [9:0] sym);
    logic [1:0] code;
    case (sym)
      TokenC1: code = 2'b01;
      TokenC2: code = 2'b10;
      TokenC3: code = 2'b11;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tmds_ch_decoder.sv
// One TMDS channel: input symbol register, registered symbol decode and the
// word-alignment state machine that requests bitslips until tokens line up.
module tmds_ch_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_TIMEOUT = 65536,
  parameter int unsigned LOSS_TIMEOUT   = 1048576,
  parameter int unsigned TOKEN_RUN      = 8,
  parameter int unsigned SLIP_WAIT      = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] sym_i,
  output logic       bitslip_o,
  output logic       aligned_o,
  output logic       ctrl_valid_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  localparam int unsigned MaxSl  = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned MaxTmo = (MaxSl > SLIP_WAIT) ? MaxSl : SLIP_WAIT;
  localparam int unsigned TmoW   = $clog2(MaxTmo + 1);
  localparam int unsigned RunW   = $clog2(TOKEN_RUN + 1);

  localparam logic [TmoW-1:0] SearchLim = TmoW'(SEARCH_TIMEOUT);
  localparam logic [TmoW-1:0] LossLim   = TmoW'(LOSS_TIMEOUT);
  localparam logic [TmoW-1:0] SlipLim   = TmoW'(SLIP_WAIT);
  localparam logic [RunW-1:0] RunLim    = RunW'(TOKEN_RUN);

  logic [9:0] sym_q;
  logic       ctrl_valid_q;
  logic [1:0] ctrl_q;
  logic [7:0] data_q;
  logic [7:0] d_unmask, data_dec;
  logic       tok;

  always_comb begin
    d_unmask    = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    data_dec    = '0;
    data_dec[0] = d_unmask[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = sym_q[8] ? (d_unmask[i] ^ d_unmask[i-1]) : ~(d_unmask[i] ^ d_unmask[i-1]);
    end
  end

  assign tok = is_token(sym_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sym_q        <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
    end else begin
      sym_q        <= sym_i;
      ctrl_valid_q <= tok;
      ctrl_q       <= token_code(sym_q);
      data_q       <= data_dec;
    end
  end

  ch_state_e       state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [RunW-1:0] run_q, run_d, run_inc;
  logic            bitslip_q, bitslip_d;
  logic            run_done;

  // Both counters saturate; run stays at TOKEN_RUN through a continuous token stream.
  assign tmo_inc  = (tmo_q == '1) ? tmo_q : tmo_q + TmoW'(1);
  assign run_inc  = (run_q >= RunLim) ? RunLim : run_q + RunW'(1);
  assign run_done = tok && (run_inc == RunLim);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    run_d     = run_q;
    bitslip_d = 1'b0;
    unique case (state_q)
      StSearch: begin
        run_d = tok ? run_inc : '0;
        tmo_d = tmo_inc;
        if (run_done) begin
          state_d = StAligned;
          tmo_d   = '0;
        end else if (tmo_inc == SearchLim) begin
          state_d   = StSlip;
          tmo_d     = '0;
          run_d     = '0;
          bitslip_d = 1'b1;
        end
      end
      StSlip: begin
        run_d = '0;
        tmo_d = tmo_inc;
        if (tmo_inc == SlipLim) begin
          state_d = StSearch;
          tmo_d   = '0;
        end
      end
      StAligned: begin
        run_d = tok ? run_inc : '0;
        tmo_d = tmo_inc;
        // A completed run wins over a simultaneous loss expiry.
        if (run_done) begin
          tmo_d = '0;
        end else if (tmo_inc == LossLim) begin
          state_d = StSearch;
          tmo_d   = '0;
          run_d   = '0;
        end
      end
      default: begin
        state_d = StSearch;
        tmo_d   = '0;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StSearch;
      tmo_q     <= '0;
      run_q     <= '0;
      bitslip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      run_q     <= run_d;
      bitslip_q <= bitslip_d;
    end
  end

  assign bitslip_o    = bitslip_q;
  assign aligned_o    = (state_q == StAligned);
  assign ctrl_valid_o = ctrl_valid_q;
  assign ctrl_o       = ctrl_q;
  assign data_o       = data_q;

endmodule

// File: rtl/tmds_rx_decoder.sv
// Three-channel TMDS receive decoder: per-channel alignment/decode plus the
// pixel combine, sync hold and registered lock indication.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_TIMEOUT = 65536,
  parameter int unsigned LOSS_TIMEOUT   = 1048576,
  parameter int unsigned TOKEN_RUN      = 8,
  parameter int unsigned SLIP_WAIT      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  tmds_red,
  input  logic [9:0]  tmds_green,
  input  logic [9:0]  tmds_blue,
  output logic [2:0]  bitslip,
  output logic [23:0] rgb,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        locked
);

  logic [9:0] ch_sym  [3];
  logic [1:0] ch_code [3];
  logic [7:0] ch_data [3];
  logic [2:0] ch_aligned;
  logic [2:0] ch_ctrl_valid;

  // Channel index matches the bitslip bit: 2 = red, 1 = green, 0 = blue.
  assign ch_sym[2] = tmds_red;
  assign ch_sym[1] = tmds_green;
  assign ch_sym[0] = tmds_blue;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    tmds_ch_decoder #(
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .LOSS_TIMEOUT  (LOSS_TIMEOUT),
      .TOKEN_RUN     (TOKEN_RUN),
      .SLIP_WAIT     (SLIP_WAIT)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .sym_i       (ch_sym[c]),
      .bitslip_o   (bitslip[c]),
      .aligned_o   (ch_aligned[c]),
      .ctrl_valid_o(ch_ctrl_valid[c]),
      .ctrl_o      (ch_code[c]),
      .data_o      (ch_data[c])
    );
  end

  logic locked_q, hs_q, vs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      locked_q <= &ch_aligned;
      if (ch_ctrl_valid[0]) begin
        hs_q <= ch_code[0][0];
        vs_q <= ch_code[0][1];
      end
    end
  end

  always_comb begin
    de  = locked_q & ~|ch_ctrl_valid;
    rgb = de ? {ch_data[2], ch_data[1], ch_data[0]} : '0;
    hs  = locked_q & (ch_ctrl_valid[0] ? ch_code[0][0] : hs_q);
    vs  = locked_q & (ch_ctrl_valid[0] ? ch_code[0][1] : vs_q);
  end

  assign locked = locked_q;

  // Only blue's control code drives sync.
  logic unused_code;
  assign unused_code = ^{ch_code[2], ch_code[1]};

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: lock, sync/data decode against an
// encoder-based reference, slip timing, loss of lock and reset during slip.
module tb_tmds_rx_decoder;

  localparam int unsigned ST = 256;
  localparam int unsigned LT = 1024;
  localparam int unsigned TR = 8;
  localparam int unsigned SW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  tmds_red, tmds_green, tmds_blue;
  logic [2:0]  bitslip;
  logic [23:0] rgb;
  logic        hs, vs, de, locked;

  int n_checks = 0;
  int n_pass = 0;

  logic hs_m = 1'b0;
  logic vs_m = 1'b0;
  logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  tmds_rx_decoder #(
    .SEARCH_TIMEOUT(ST),
    .LOSS_TIMEOUT  (LT),
    .TOKEN_RUN     (TR),
    .SLIP_WAIT     (SW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tmds_red  (tmds_red),
    .tmds_green(tmds_green),
    .tmds_blue (tmds_blue),
    .bitslip   (bitslip),
    .rgb       (rgb),
    .hs        (hs),
    .vs        (vs),
    .de        (de),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  function automatic logic is_tok(logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  function automatic logic [1:0] tok_code(logic [9:0] s);
    case (s)
      10'h0AB: return 2'd1;
      10'h154: return 2'd2;
      10'h2AB: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Transmitter-side encoding of pixel p; the decoder must recover p exactly.
  function automatic logic [9:0] encode(logic [7:0] p, logic q8, logic q9);
    logic [7:0] m;
    m = '0;
    m[0] = p[0];
    for (int i = 1; i < 8; i++) m[i] = q8 ? (m[i-1] ^ p[i]) : ~(m[i-1] ^ p[i]);
    return {q9, q8, q9 ? ~m : m};
  endfunction

  task automatic gen_symbol(input logic want_tok, output logic [9:0] s, output logic [7:0] p);
    if (want_tok) begin
      s = toks[$urandom_range(0, 3)];
      p = 8'h00;
    end else begin
      do begin
        p = 8'($urandom);
        s = encode(p, 1'($urandom), 1'($urandom));
      end while (is_tok(s));
    end
  endtask

  task automatic model(input logic [29:0] w, input logic [23:0] pw, output logic [23:0] e_rgb,
                       output logic e_de, output logic e_hs, output logic e_vs);
    logic [1:0] code;
    e_de  = !is_tok(w[29:20]) && !is_tok(w[19:10]) && !is_tok(w[9:0]);
    e_rgb = e_de ? pw : 24'h0;
    if (is_tok(w[9:0])) begin
      code = tok_code(w[9:0]);
      hs_m = code[0];
      vs_m = code[1];
    end
    e_hs = hs_m;
    e_vs = vs_m;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tmds_red = 10'($urandom);
    tmds_green = 10'($urandom);
    tmds_blue = 10'($urandom);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bitslip !== 3'b000) $display("FAIL reset_bitslip: got %b expected 000", bitslip); else n_pass++;
    n_checks++; if (rgb !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", rgb); else n_pass++;
    n_checks++; if (hs !== 1'b0) $display("FAIL reset_hs: got %b expected 0", hs); else n_pass++;
    n_checks++; if (vs !== 1'b0) $display("FAIL reset_vs: got %b expected 0", vs); else n_pass++;
    n_checks++; if (de !== 1'b0) $display("FAIL reset_de: got %b expected 0", de); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_token_lock();
    int lock_e;
    lock_e = 0;
    @(negedge clk);
    {tmds_red, tmds_green, tmds_blue} = {3{10'h354}};
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (locked === 1'b1) begin
        lock_e = e;
        break;
      end
    end
    n_checks++; if (lock_e != TR + 2) $display("FAIL lock_latency: got %0d expected %0d", lock_e, TR + 2); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (locked !== 1'b1) $display("FAIL lock_held: got %b expected 1", locked); else n_pass++;
    n_checks++; if (hs !== 1'b0) $display("FAIL lock_hs: got %b expected 0", hs); else n_pass++;
    n_checks++; if (vs !== 1'b0) $display("FAIL lock_vs: got %b expected 0", vs); else n_pass++;
    n_checks++; if (de !== 1'b0) $display("FAIL lock_de: got %b expected 0", de); else n_pass++;
    n_checks++; if (rgb !== 24'h0) $display("FAIL lock_rgb: got %h expected 000000", rgb); else n_pass++;
  endtask

  task automatic test_sync_decode();
    logic [29:0] syms[$];
    logic [23:0] pixs[$], x_rgb[$];
    logic        x_de[$], x_hs[$], x_vs[$];
    logic [9:0]  s;
    logic [7:0]  p;
    logic [23:0] er;
    logic        ed, eh, ev;
    syms.push_back({10'h354, 10'h354, 10'h0AB}); syms.push_back({10'h354, 10'h354, 10'h0AB});
    syms.push_back({10'h354, 10'h354, 10'h2AB}); syms.push_back({10'h354, 10'h354, 10'h2AB});
    repeat (4) pixs.push_back(24'h0);
    for (int k = 0; k < 16; k++) begin
      gen_symbol(1'b1, s, p);
      syms.push_back({10'h354, 10'h354, s});
      pixs.push_back(24'h0);
    end
    for (int k = 0; k < 4; k++) begin
      gen_symbol(1'b0, s, p);
      syms.push_back({10'h354, 10'h354, s});
      pixs.push_back(24'h0);
    end
    repeat (10) begin
      syms.push_back({3{10'h354}});
      pixs.push_back(24'h0);
    end
    foreach (syms[i]) begin
      model(syms[i], pixs[i], er, ed, eh, ev);
      x_rgb.push_back(er); x_de.push_back(ed); x_hs.push_back(eh); x_vs.push_back(ev);
    end
    for (int i = 0; i <= syms.size(); i++) begin
      @(negedge clk);
      if (i < syms.size()) {tmds_red, tmds_green, tmds_blue} = syms[i];
      @(posedge clk); #1;
      if (i >= 1) begin
        n_checks++; if (hs !== x_hs[i-1]) $display("FAIL sync_hs[%0d]: got %b expected %b", i - 1, hs, x_hs[i-1]); else n_pass++;
        n_checks++; if (vs !== x_vs[i-1]) $display("FAIL sync_vs[%0d]: got %b expected %b", i - 1, vs, x_vs[i-1]); else n_pass++;
        n_checks++; if (de !== x_de[i-1]) $display("FAIL sync_de[%0d]: got %b expected %b", i - 1, de, x_de[i-1]); else n_pass++;
        n_checks++; if (rgb !== x_rgb[i-1]) $display("FAIL sync_rgb[%0d]: got %h expected %h", i - 1, rgb, x_rgb[i-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_data_decode();
    logic [29:0] syms[$];
    logic [23:0] pixs[$], x_rgb[$];
    logic        x_de[$], x_hs[$], x_vs[$];
    logic [29:0] w;
    logic [23:0] pw;
    logic [9:0]  s;
    logic [7:0]  p;
    logic [23:0] er;
    logic        ed, eh, ev;
    repeat (3) begin syms.push_back({3{10'h100}}); pixs.push_back(24'h000000); end
    repeat (3) begin syms.push_back({3{10'h200}}); pixs.push_back(24'hFFFFFF); end
    for (int k = 0; k < 60; k++) begin
      w = '0;
      pw = '0;
      for (int c = 0; c < 3; c++) begin
        gen_symbol($urandom_range(0, 5) == 0, s, p);
        w[29-10*c -: 10] = s;
        pw[23-8*c -: 8] = p;
      end
      syms.push_back(w);
      pixs.push_back(pw);
    end
    repeat (10) begin syms.push_back({3{10'h354}}); pixs.push_back(24'h0); end
    foreach (syms[i]) begin
      model(syms[i], pixs[i], er, ed, eh, ev);
      x_rgb.push_back(er); x_de.push_back(ed); x_hs.push_back(eh); x_vs.push_back(ev);
    end
    for (int i = 0; i <= syms.size(); i++) begin
      @(negedge clk);
      if (i < syms.size()) {tmds_red, tmds_green, tmds_blue} = syms[i];
      @(posedge clk); #1;
      if (i >= 1) begin
        n_checks++; if (rgb !== x_rgb[i-1]) $display("FAIL data_rgb[%0d]: got %h expected %h", i - 1, rgb, x_rgb[i-1]); else n_pass++;
        n_checks++; if (de !== x_de[i-1]) $display("FAIL data_de[%0d]: got %b expected %b", i - 1, de, x_de[i-1]); else n_pass++;
        n_checks++; if (hs !== x_hs[i-1]) $display("FAIL data_hs[%0d]: got %b expected %b", i - 1, hs, x_hs[i-1]); else n_pass++;
        n_checks++; if (vs !== x_vs[i-1]) $display("FAIL data_vs[%0d]: got %b expected %b", i - 1, vs, x_vs[i-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_loss();
    int fall_e, n_slip;
    fall_e = 0;
    n_slip = 0;
    @(negedge clk);
    {tmds_red, tmds_green, tmds_blue} = {3{10'h100}};
    for (int e = 1; e <= LT + 4; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin
        n_checks++; if (de !== 1'b1) $display("FAIL loss_de_start: got %b expected 1", de); else n_pass++;
        n_checks++; if (rgb !== 24'h0) $display("FAIL loss_rgb_start: got %h expected 000000", rgb); else n_pass++;
      end
      if (bitslip !== 3'b000) n_slip++;
      if (fall_e == 0 && locked !== 1'b1) fall_e = e;
    end
    n_checks++; if (fall_e != LT + 2) $display("FAIL loss_unlock_cycle: got %0d expected %0d", fall_e, LT + 2); else n_pass++;
    n_checks++; if (n_slip != 0) $display("FAIL loss_no_bitslip: got %0d pulses expected 0", n_slip); else n_pass++;
    n_checks++; if (de !== 1'b0) $display("FAIL loss_de_after: got %b expected 0", de); else n_pass++;
  endtask

  task automatic test_slip();
    int first_e, second_e, n_pulse;
    logic [2:0] first_v, second_v;
    first_e = 0; second_e = 0; n_pulse = 0; first_v = '0; second_v = '0;
    @(negedge clk);
    reset_n = 1'b0;
    {tmds_red, tmds_green, tmds_blue} = {3{10'h100}};
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 2 * ST + SW + 16; e++) begin
      @(posedge clk); #1;
      if (bitslip !== 3'b000) begin
        n_pulse++;
        if (n_pulse == 1) begin first_e = e; first_v = bitslip; end
        else if (n_pulse == 2) begin second_e = e; second_v = bitslip; end
      end
    end
    n_checks++; if (first_e != ST) $display("FAIL slip_first_cycle: got %0d expected %0d", first_e, ST); else n_pass++;
    n_checks++; if (first_v !== 3'b111) $display("FAIL slip_first_value: got %b expected 111", first_v); else n_pass++;
    n_checks++; if (second_e != 2 * ST + SW) $display("FAIL slip_second_cycle: got %0d expected %0d", second_e, 2 * ST + SW); else n_pass++;
    n_checks++; if (second_v !== 3'b111) $display("FAIL slip_second_value: got %b expected 111", second_v); else n_pass++;
    n_checks++; if (n_pulse != 2) $display("FAIL slip_pulse_count: got %0d expected 2", n_pulse); else n_pass++;
  endtask

  task automatic test_reset_mid_slip();
    int first_e, n_pulse;
    first_e = 0;
    n_pulse = 0;
    @(negedge clk);
    reset_n = 1'b0;
    {tmds_red, tmds_green, tmds_blue} = {3{10'h200}};
    @(negedge clk);
    reset_n = 1'b1;
    repeat (ST) @(posedge clk);
    #1;
    n_checks++; if (bitslip !== 3'b111) $display("FAIL mid_slip_pulse: got %b expected 111", bitslip); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (bitslip !== 3'b000) $display("FAIL mid_slip_abort: got %b expected 000", bitslip); else n_pass++;
    n_checks++; if ({rgb, hs, vs, de, locked} !== 28'h0) $display("FAIL mid_slip_outputs: got %h expected 0", {rgb, hs, vs, de, locked}); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= ST + 8; e++) begin
      @(posedge clk); #1;
      if (bitslip !== 3'b000) begin
        n_pulse++;
        if (n_pulse == 1) first_e = e;
      end
    end
    n_checks++; if (first_e != ST) $display("FAIL mid_slip_restart: got %0d expected %0d", first_e, ST); else n_pass++;
    n_checks++; if (n_pulse != 1) $display("FAIL mid_slip_count: got %0d expected 1", n_pulse); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_token_lock();
    test_sync_decode();
    test_data_decode();
    test_loss();
    test_slip();
    test_reset_mid_slip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
